// File: rtl/tcdm_xbar_pkg.sv
// Shared types and helpers for the TCDM request crossbar.
// Consumed by tcdm_xbar_interconnect and its per-bank arbiter.
package tcdm_xbar_pkg;

    typedef enum logic {
        TOPO_LIC  = 1'b0,
        TOPO_BFLY = 1'b1
    } topo_e;

    // Byte offset of the word index inside a master address.
    function automatic int unsigned addr_off(input int unsigned dw);
        return $clog2(dw - 1) - 3;
    endfunction

endpackage

// File: rtl/tcdm_xbar_rr_arb.sv
// Round-robin arbiter: the search starts at ptr_i and wraps around.
// Produces a one-hot grant, the winner index, and an any-grant flag.
module tcdm_xbar_rr_arb #(
    parameter int unsigned NumIn = 16,
    localparam int unsigned IdxW = (NumIn > 1) ? $clog2(NumIn) : 1
) (
    input  logic [NumIn-1:0] req_i,
    input  logic [IdxW-1:0]  ptr_i,
    output logic [NumIn-1:0] gnt_o,
    output logic [IdxW-1:0]  idx_o,
    output logic             vld_o
);

    always_comb begin
        int unsigned cand;
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        cand  = 0;
        for (int unsigned i = 0; i < NumIn; i++) begin
            cand = 32'(ptr_i) + i;
            if (cand >= NumIn) begin
                cand = cand - NumIn;
            end
            if (!vld_o && req_i[cand[IdxW-1:0]]) begin
                vld_o = 1'b1;
                idx_o = cand[IdxW-1:0];
            end
        end
        gnt_o[idx_o] = vld_o;
    end

endmodule

// File: rtl/tcdm_xbar_interconnect.sv
// Word-interleaved TCDM crossbar: per-bank round-robin, 1-cycle response.
// Define TCDM_XBAR_ASSERT_EN to include simulation assertions.
module tcdm_xbar_interconnect
    import tcdm_xbar_pkg::*;
#(
    parameter int unsigned NumMaster    = 16,
    parameter int unsigned NumSlave     = 32,
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddrMemWidth = 12,
    parameter int unsigned Topology     = 0
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NumMaster-1:0]              req_i,
    input  logic [NumMaster*AddrWidth-1:0]    add_i,
    input  logic [NumMaster-1:0]              wen_i,
    input  logic [NumMaster*DataWidth-1:0]    wdata_i,
    input  logic [NumMaster*DataWidth/8-1:0]  be_i,
    output logic [NumMaster-1:0]              gnt_o,
    output logic [NumMaster-1:0]              rvld_o,
    output logic [NumMaster*DataWidth-1:0]    rdata_o,
    output logic [NumSlave-1:0]               cs_o,
    output logic [NumSlave*AddrMemWidth-1:0]  add_o,
    output logic [NumSlave-1:0]               wen_o,
    output logic [NumSlave*DataWidth-1:0]     wdata_o,
    output logic [NumSlave*DataWidth/8-1:0]   be_o,
    input  logic [NumSlave*DataWidth-1:0]     rdata_i
);

    localparam int unsigned Off   = addr_off(DataWidth);
    localparam int unsigned BankW = $clog2(NumSlave);
    localparam int unsigned IdxW  = (NumMaster > 1) ? $clog2(NumMaster) : 1;
    localparam int unsigned BeW   = DataWidth / 8;

    if ((Topology != int'(TOPO_LIC)) && (Topology != int'(TOPO_BFLY))) begin : g_bad_topo
        $error("tcdm_xbar_interconnect: unsupported Topology");
    end
    if ((NumSlave < 2) || ((NumSlave & (NumSlave - 1)) != 0)) begin : g_bad_banks
        $error("tcdm_xbar_interconnect: NumSlave must be a power of two >= 2");
    end

    logic [NumMaster-1:0][BankW-1:0]        bank_sel;
    logic [NumMaster-1:0][AddrMemWidth-1:0] word_sel;
    logic                                   unused_add;

    for (genvar m = 0; m < NumMaster; m++) begin : g_dec
        assign bank_sel[m] = add_i[m*AddrWidth+Off +: BankW];
        assign word_sel[m] = add_i[m*AddrWidth+Off+BankW +: AddrMemWidth];
    end
    assign unused_add = ^add_i;

    logic [NumSlave-1:0][NumMaster-1:0] bank_req;
    logic [NumSlave-1:0][NumMaster-1:0] bank_gnt;
    logic [NumSlave-1:0][IdxW-1:0]      win;
    logic [NumSlave-1:0]                bank_vld;

    always_comb begin
        bank_req = '0;
        for (int unsigned m = 0; m < NumMaster; m++) begin
            bank_req[bank_sel[m]][m] = req_i[m];
        end
    end

    logic [NumSlave-1:0][IdxW-1:0] ptr_q, ptr_d;
    logic [NumSlave-1:0][IdxW-1:0] win_q, win_d;
    logic [NumSlave-1:0]           vld_q, vld_d;

    for (genvar b = 0; b < NumSlave; b++) begin : g_bank
        tcdm_xbar_rr_arb #(
            .NumIn (NumMaster)
        ) u_arb (
            .req_i (bank_req[b]),
            .ptr_i (ptr_q[b]),
            .gnt_o (bank_gnt[b]),
            .idx_o (win[b]),
            .vld_o (bank_vld[b])
        );

        assign cs_o[b]                              = bank_vld[b];
        assign add_o[b*AddrMemWidth +: AddrMemWidth] = word_sel[win[b]];
        assign wen_o[b]                             = wen_i[win[b]];
        assign wdata_o[b*DataWidth +: DataWidth]    = wdata_i[win[b]*DataWidth +: DataWidth];
        assign be_o[b*BeW +: BeW]                   = be_i[win[b]*BeW +: BeW];
    end

    always_comb begin
        gnt_o = '0;
        for (int unsigned b = 0; b < NumSlave; b++) begin
            gnt_o = gnt_o | bank_gnt[b];
        end
    end

    // Pointer moves just past the winner; idle banks keep their pointer.
    always_comb begin
        ptr_d = ptr_q;
        win_d = win_q;
        vld_d = bank_vld;
        for (int unsigned b = 0; b < NumSlave; b++) begin
            if (bank_vld[b]) begin
                win_d[b] = win[b];
                if (32'(win[b]) == NumMaster - 1) begin
                    ptr_d[b] = '0;
                end else begin
                    ptr_d[b] = win[b] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
            win_q <= '0;
            vld_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            win_q <= win_d;
            vld_q <= vld_d;
        end
    end

    // A master targets one bank per cycle, so responses never collide.
    always_comb begin
        rvld_o  = '0;
        rdata_o = '0;
        for (int unsigned b = 0; b < NumSlave; b++) begin
            if (vld_q[b]) begin
                rvld_o[win_q[b]] = 1'b1;
                rdata_o[win_q[b]*DataWidth +: DataWidth] = rdata_i[b*DataWidth +: DataWidth];
            end
        end
    end

`ifdef TCDM_XBAR_ASSERT_EN
    a_gnt_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (gnt_o & ~req_i) == '0);

    a_rvld_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !$isunknown(rvld_o));

    for (genvar b = 0; b < NumSlave; b++) begin : g_a_bank
        a_one_gnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
            $onehot0(bank_gnt[b]));
    end

    for (genvar m = 0; m < NumMaster; m++) begin : g_a_mst
        a_rd_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (gnt_o[m] && !wen_i[m]) |=> rvld_o[m]);
    end
`endif

endmodule

// File: tb/tb_tcdm_xbar_interconnect.sv
// Scoreboard bench for tcdm_xbar_interconnect with a behavioural SRAM per bank.
// Expected grants/responses are queued by stimulus and checked by a monitor.
module tb_tcdm_xbar_interconnect;

    localparam int NM = 16;
    localparam int NS = 32;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NM-1:0]      req, wen, gnt, rvld;
    logic [NM*AW-1:0]   add;
    logic [NM*DW-1:0]   wdata, rdata;
    logic [NM*4-1:0]    be;
    logic [NS-1:0]      cs, wen_o;
    logic [NS*MW-1:0]   add_o;
    logic [NS*DW-1:0]   wdata_o;
    logic [NS*DW-1:0]   rdata_i = '0;
    logic [NS*4-1:0]    be_o;

    tcdm_xbar_interconnect dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .req_i   (req),
        .add_i   (add),
        .wen_i   (wen),
        .wdata_i (wdata),
        .be_i    (be),
        .gnt_o   (gnt),
        .rvld_o  (rvld),
        .rdata_o (rdata),
        .cs_o    (cs),
        .add_o   (add_o),
        .wen_o   (wen_o),
        .wdata_o (wdata_o),
        .be_o    (be_o),
        .rdata_i (rdata_i)
    );

    typedef struct {
        logic [NM-1:0] gnt;
        logic [NS-1:0] cs;
        bit            ack;
        int            ab;
        logic [MW-1:0] aw;
    } gexp_t;

    typedef struct {
        logic [NM-1:0]         vld;
        logic [NM-1:0]         chk;
        logic [NM-1:0][DW-1:0] d;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    int n_chk = 0;
    int n_fail = 0;
    int gcnt[NM];
    bit t3_on = 1'b0;
    logic [31:0] ref_wr[int];
    logic [31:0] smem[int];

    logic [NS-1:0]    s_cs = '0;
    logic [NS-1:0]    s_wen = '0;
    logic [NS*MW-1:0] s_add = '0;
    logic [NS*DW-1:0] s_wd = '0;
    logic [NS*4-1:0]  s_be = '0;

    function automatic logic [31:0] init_val(input int b, input int w);
        return {8'(b), 8'h5A, 16'(w)} ^ 32'h0000_3C00;
    endfunction

    function automatic logic [31:0] exp_val(input int b, input int w);
        int k = b * 4096 + w;
        return ref_wr.exists(k) ? ref_wr[k] : init_val(b, w);
    endfunction

    function automatic logic [31:0] addr(input int b, input int w);
        return (32'(w) << 7) | (32'(b) << 2);
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm, input string why);
        n_chk++;
        n_fail++;
        $display("FAIL %s: %s", nm, why);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        req = '0;
        add = '0;
        wen = '0;
        wdata = '0;
        be = '0;
    endtask

    task automatic set_m(input int m, input logic [31:0] a, input logic w,
                         input logic [31:0] d, input logic [3:0] b);
        req[m] = 1'b1;
        add[m*AW +: AW] = a;
        wen[m] = w;
        wdata[m*DW +: DW] = d;
        be[m*4 +: 4] = b;
    endtask

    task automatic push_g(input logic [NM-1:0] g, input logic [NS-1:0] c,
                          input bit ack, input int ab, input int aw);
        gexp_t e;
        e.gnt = g;
        e.cs = c;
        e.ack = ack;
        e.ab = ab;
        e.aw = MW'(aw);
        gq.push_back(e);
    endtask

    // Negedge: sample combinational outputs, capture bank request for the SRAM.
    always @(negedge clk) begin
        gexp_t g;
        rexp_t r;
        logic any;
        s_cs = cs;
        s_add = add_o;
        s_wen = wen_o;
        s_wd = wdata_o;
        s_be = be_o;
        if (rst_n) begin
            if (t3_on) begin
                for (int m = 0; m < NM; m++) if (gnt[m]) gcnt[m]++;
            end
            if (req != '0) begin
                if (gq.size() == 0) begin
                    fail("gnt_queue", "request with no expected grant");
                end else begin
                    g = gq.pop_front();
                    check("gnt", 64'(gnt), 64'(g.gnt));
                    check("cs", 64'(cs), 64'(g.cs));
                    if (g.ack) begin
                        check("add_o", 64'(add_o[g.ab*MW +: MW]), 64'(g.aw));
                    end
                end
            end
            if (rvld != '0) begin
                if (rq.size() == 0) begin
                    fail("rsp_queue", "rvld with no expected response");
                end else begin
                    r = rq.pop_front();
                    check("rvld", 64'(rvld), 64'(r.vld));
                    for (int m = 0; m < NM; m++) begin
                        if (r.chk[m] && r.vld[m]) begin
                            check($sformatf("rdata_m%0d", m), 64'(rdata[m*DW +: DW]), 64'(r.d[m]));
                        end
                    end
                    any = 1'b0;
                    for (int m = 0; m < NM; m++) begin
                        if (!rvld[m]) any = any | (|rdata[m*DW +: DW]);
                    end
                    check("rdata_idle", 64'(any), 64'(0));
                end
            end
        end
    end

    // Bank SRAMs: read-before-write, data one cycle after chip select.
    always @(posedge clk) begin
        int k;
        int w;
        logic [31:0] cur;
        for (int b = 0; b < NS; b++) begin
            if (s_cs[b]) begin
                w = int'(s_add[b*MW +: MW]);
                k = b * 4096 + w;
                cur = smem.exists(k) ? smem[k] : init_val(b, w);
                rdata_i[b*DW +: DW] <= cur;
                if (s_wen[b]) begin
                    for (int j = 0; j < 4; j++) begin
                        if (s_be[b*4+j]) cur[j*8 +: 8] = s_wd[b*DW+j*8 +: 8];
                    end
                    smem[k] = cur;
                end
            end
        end
    end

    initial begin
        rexp_t e;
        int bk;
        for (int m = 0; m < NM; m++) gcnt[m] = 0;
        clr();
        #1;
        check("rst_rvld", 64'(rvld), 64'(0));
        check("rst_rdata", 64'(|rdata), 64'(0));
        check("rst_cs", 64'(cs), 64'(0));
        check("rst_gnt", 64'(gnt), 64'(0));
        step();
        step();
        rst_n = 1'b1;
        #1;
        check("idle_cs", 64'(cs), 64'(0));

        // T1: single read, master 3, 0x84 -> bank 1, word 1
        set_m(3, 32'h0000_0084, 1'b0, 32'h0, 4'hF);
        push_g(16'h0008, 32'h0000_0002, 1'b1, 1, 1);
        e.vld = 16'h0008; e.chk = 16'h0008; e.d = '0;
        e.d[3] = 32'h015A_3C01;
        rq.push_back(e);
        step();
        clr();
        step();
        step();

        // T2: distinct banks, three back-to-back patterns
        for (int k = 0; k < 3; k++) begin
            e.vld = '1; e.chk = '1; e.d = '0;
            for (int m = 0; m < NM; m++) begin
                bk = (k == 2) ? m + 16 : m;
                set_m(m, addr(bk, k), 1'b0, 32'h0, 4'hF);
                e.d[m] = exp_val(bk, k);
            end
            push_g('1, (k == 2) ? 32'hFFFF_0000 : 32'h0000_FFFF, 1'b1, (k == 2) ? 16 : 0, k);
            rq.push_back(e);
            step();
        end
        clr();
        step();
        step();

        // T4: partial write then read of the same word
        set_m(2, 32'h0000_1008, 1'b1, 32'hAABB_CCDD, 4'b0101);
        push_g(16'h0004, 32'h0000_0004, 1'b1, 2, 32);
        e.vld = 16'h0004; e.chk = '0; e.d = '0;
        rq.push_back(e);
        ref_wr[2*4096+32] = 32'h02BB_3CDD;
        step();
        set_m(2, 32'h0000_1008, 1'b0, 32'h0, 4'hF);
        push_g(16'h0004, 32'h0000_0004, 1'b1, 2, 32);
        e.vld = 16'h0004; e.chk = 16'h0004; e.d = '0;
        e.d[2] = 32'h02BB_3CDD;
        rq.push_back(e);
        step();
        clr();
        step();
        step();

        // T6: reset right after a grant drops the response
        set_m(3, addr(1, 1), 1'b0, 32'h0, 4'hF);
        push_g(16'h0008, 32'h0000_0002, 1'b0, 0, 0);
        step();
        rst_n = 1'b0;
        clr();
        #1;
        check("midrst_rvld", 64'(rvld), 64'(0));
        check("midrst_rdata", 64'(|rdata), 64'(0));
        check("midrst_cs", 64'(cs), 64'(0));
        step();
        step();
        rst_n = 1'b1;
        e.vld = 16'h0001; e.chk = 16'h0001; e.d = '0;
        for (int m = 0; m < NM; m++) set_m(m, addr(7, m), 1'b0, 32'h0, 4'hF);
        e.d[0] = exp_val(7, 0);
        push_g(16'h0001, 32'h0000_0080, 1'b1, 7, 0);
        rq.push_back(e);
        step();
        clr();
        step();
        step();

        // T3: all masters hold a read on bank 5 for 32 cycles
        for (int m = 0; m < NM; m++) set_m(m, addr(5, m), 1'b0, 32'h0, 4'hF);
        t3_on = 1'b1;
        for (int c = 0; c < 32; c++) begin
            e.vld = NM'(1) << (c % NM); e.chk = e.vld; e.d = '0;
            e.d[c % NM] = exp_val(5, c % NM);
            push_g(NM'(1) << (c % NM), 32'h0000_0020, 1'b0, 0, 0);
            rq.push_back(e);
            step();
        end
        clr();
        step();
        t3_on = 1'b0;
        for (int m = 0; m < NM; m++) check($sformatf("rr_count_m%0d", m), 64'(gcnt[m]), 64'(2));
        step();

        // T7: partial conflict on bank 12 plus an independent bank 3 read
        set_m(4, addr(12, 1), 1'b0, 32'h0, 4'hF);
        set_m(9, addr(12, 2), 1'b0, 32'h0, 4'hF);
        set_m(0, addr(3, 0), 1'b0, 32'h0, 4'hF);
        push_g(16'h0011, 32'h0000_1008, 1'b1, 12, 1);
        e.vld = 16'h0011; e.chk = 16'h0011; e.d = '0;
        e.d[4] = exp_val(12, 1);
        e.d[0] = exp_val(3, 0);
        rq.push_back(e);
        step();
        req[4] = 1'b0;
        req[0] = 1'b0;
        push_g(16'h0200, 32'h0000_1000, 1'b1, 12, 2);
        e.vld = 16'h0200; e.chk = 16'h0200; e.d = '0;
        e.d[9] = exp_val(12, 2);
        rq.push_back(e);
        step();
        req[4] = 1'b1;
        push_g(16'h0010, 32'h0000_1000, 1'b1, 12, 1);
        e.vld = 16'h0010; e.chk = 16'h0010; e.d = '0;
        e.d[4] = exp_val(12, 1);
        rq.push_back(e);
        step();
        push_g(16'h0200, 32'h0000_1000, 1'b1, 12, 2);
        e.vld = 16'h0200; e.chk = 16'h0200; e.d = '0;
        e.d[9] = exp_val(12, 2);
        rq.push_back(e);
        step();
        clr();
        step();
        step();

        check("gnt_left", 64'(gq.size()), 64'(0));
        check("rsp_left", 64'(rq.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
